// File: rtl/apu_shared_unit_arbiter_pkg.sv
// Shared APU cluster constants and helpers.
// Holds the FP width, per-unit-type opcode/flag widths and pipeline depths used as
// defaults by the shared-unit arbiter, plus the core-ID width helper and the minimum
// legal unit latency.
package apu_shared_unit_arbiter_pkg;

  localparam int unsigned FP_WIDTH = 32;

  // Unit latencies in cycles.
  localparam int unsigned C_ADDSUB_PIPE_REGS = 1;
  localparam int unsigned C_MULT_PIPE_REGS   = 1;
  localparam int unsigned C_MAC_PIPE_REGS    = 2;
  localparam int unsigned C_CAST_PIPE_REGS   = 1;
  localparam int unsigned C_DIV_PIPE_REGS    = 4;
  localparam int unsigned C_SQRT_PIPE_REGS   = 5;

  // Opcode widths.
  localparam int unsigned WOP_ADDSUB = 1;
  localparam int unsigned WOP_MULT   = 1;
  localparam int unsigned WOP_MAC    = 2;
  localparam int unsigned WOP_CAST   = 2;
  localparam int unsigned WOP_DIV    = 1;
  localparam int unsigned WOP_SQRT   = 1;

  // Downstream flags (rounding mode).
  localparam int unsigned NDSFLAGS_ADDSUB = 3;
  localparam int unsigned NDSFLAGS_MULT   = 3;
  localparam int unsigned NDSFLAGS_MAC    = 3;
  localparam int unsigned NDSFLAGS_CAST   = 3;
  localparam int unsigned NDSFLAGS_DIV    = 3;
  localparam int unsigned NDSFLAGS_SQRT   = 3;

  // Upstream status flags.
  localparam int unsigned NUSFLAGS_ADDSUB = 5;
  localparam int unsigned NUSFLAGS_MULT   = 5;
  localparam int unsigned NUSFLAGS_MAC    = 5;
  localparam int unsigned NUSFLAGS_CAST   = 5;
  localparam int unsigned NUSFLAGS_DIV    = 5;
  localparam int unsigned NUSFLAGS_SQRT   = 5;

  // A shared unit needs at least one pipeline stage to carry the issuing core ID.
  localparam int unsigned MIN_PIPE_REGS = 1;

  // Width of an encoded core ID; a single core still needs one bit.
  function automatic int unsigned shared_id_width(int unsigned ncores);
    return (ncores > 1) ? $clog2(ncores) : 1;
  endfunction

endpackage

// File: rtl/apu_rr_arbiter.sv
// Round-robin request arbiter.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : per-core request vector
//   gnt_o        : one-hot grant (combinational, zero while in reset)
//   id_o         : encoded index of the granted core (rr_ptr_o when nothing granted)
//   valid_o      : a grant is issued this cycle
//   rr_ptr_o     : current search start position
module apu_rr_arbiter
  import apu_shared_unit_arbiter_pkg::*;
#(
  parameter int unsigned NCORES = 8,
  parameter int unsigned IDW    = shared_id_width(NCORES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NCORES-1:0] req_i,
  output logic [NCORES-1:0] gnt_o,
  output logic [IDW-1:0]    id_o,
  output logic              valid_o,
  output logic [IDW-1:0]    rr_ptr_o
);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] idx;
  int unsigned    pos;

  // Walk the request vector starting at the pointer, wrapping modulo NCORES.
  always_comb begin
    gnt_o   = '0;
    id_o    = rr_ptr_q;
    valid_o = 1'b0;
    pos     = 0;
    idx     = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      pos = 32'(rr_ptr_q) + i;
      if (pos >= NCORES) pos = pos - NCORES;
      idx = IDW'(pos);
      if (!valid_o && !rst_i && req_i[idx]) begin
        valid_o    = 1'b1;
        id_o       = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (valid_o) begin
      rr_ptr_d = (id_o == IDW'(NCORES - 1)) ? '0 : id_o + IDW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr_o = rr_ptr_q;

endmodule

// File: rtl/apu_shared_unit_arbiter.sv
// Shares one fixed-latency, fully pipelined FP unit between NCORES cores.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   core_req_i          : per-core request
//   core_operands_i     : NARGS*WARG operands per core, core c in slice c
//   core_op_i           : per-core opcode
//   core_flags_i        : per-core downstream flags
//   core_gnt_o          : one-hot grant (combinational)
//   core_rvalid_o       : one-hot result valid
//   core_result_o       : unit result, broadcast
//   core_rflags_o       : unit status flags, broadcast
//   unit_en_o           : issue strobe to the unit
//   unit_operands_o     : granted core's operands
//   unit_op_o           : granted core's opcode
//   unit_flags_o        : granted core's downstream flags
//   unit_result_i       : unit result, PIPE_REGS cycles after unit_en_o
//   unit_flags_i        : unit status flags aligned with unit_result_i
//   unit_busy_o         : at least one operation in flight
module apu_shared_unit_arbiter
  import apu_shared_unit_arbiter_pkg::*;
#(
  parameter int unsigned NCORES    = 8,
  parameter int unsigned NARGS     = 3,
  parameter int unsigned WARG      = FP_WIDTH,
  parameter int unsigned WRESULT   = FP_WIDTH,
  parameter int unsigned WOP       = WOP_MAC,
  parameter int unsigned NDSFLAGS  = NDSFLAGS_MAC,
  parameter int unsigned NUSFLAGS  = NUSFLAGS_MAC,
  parameter int unsigned PIPE_REGS = C_MAC_PIPE_REGS
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NCORES-1:0]                core_req_i,
  input  logic [NCORES*NARGS*WARG-1:0]     core_operands_i,
  input  logic [NCORES*WOP-1:0]            core_op_i,
  input  logic [NCORES*NDSFLAGS-1:0]       core_flags_i,
  output logic [NCORES-1:0]                core_gnt_o,
  output logic [NCORES-1:0]                core_rvalid_o,
  output logic [WRESULT-1:0]               core_result_o,
  output logic [NUSFLAGS-1:0]              core_rflags_o,
  output logic                             unit_en_o,
  output logic [NARGS*WARG-1:0]            unit_operands_o,
  output logic [WOP-1:0]                   unit_op_o,
  output logic [NDSFLAGS-1:0]              unit_flags_o,
  input  logic [WRESULT-1:0]               unit_result_i,
  input  logic [NUSFLAGS-1:0]              unit_flags_i,
  output logic                             unit_busy_o
);

  localparam int unsigned IDW  = shared_id_width(NCORES);
  localparam int unsigned WOPS = NARGS * WARG;

  if (PIPE_REGS < MIN_PIPE_REGS) begin : g_bad_pipe_regs
    $error("apu_shared_unit_arbiter: PIPE_REGS must be at least 1");
  end

  logic           arb_valid;
  logic [IDW-1:0] arb_id;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] sel;

  apu_rr_arbiter #(
    .NCORES (NCORES),
    .IDW    (IDW)
  ) u_rr_arbiter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (core_req_i),
    .gnt_o    (core_gnt_o),
    .id_o     (arb_id),
    .valid_o  (arb_valid),
    .rr_ptr_o (rr_ptr)
  );

  // Unpack per-core slices so the mux indexes an array instead of a computed bit offset.
  logic [WOPS-1:0]     ops_arr   [NCORES];
  logic [WOP-1:0]      op_arr    [NCORES];
  logic [NDSFLAGS-1:0] flags_arr [NCORES];

  for (genvar c = 0; c < NCORES; c++) begin : g_unpack
    assign ops_arr[c]   = core_operands_i[c*WOPS +: WOPS];
    assign op_arr[c]    = core_op_i[c*WOP +: WOP];
    assign flags_arr[c] = core_flags_i[c*NDSFLAGS +: NDSFLAGS];
  end

  // With no grant, present the pointer's slice so the idle outputs stay deterministic.
  assign sel             = arb_valid ? arb_id : rr_ptr;
  assign unit_en_o       = arb_valid;
  assign unit_operands_o = ops_arr[sel];
  assign unit_op_o       = op_arr[sel];
  assign unit_flags_o    = flags_arr[sel];

  // Tag pipeline: carries {valid, id} alongside the operation inside the unit.
  logic [PIPE_REGS-1:0] tag_valid_q, tag_valid_d;
  logic [IDW-1:0]       tag_id_q [PIPE_REGS];
  logic [IDW-1:0]       tag_id_d [PIPE_REGS];

  always_comb begin
    tag_valid_d    = tag_valid_q;
    tag_valid_d[0] = arb_valid;
    tag_id_d       = tag_id_q;
    tag_id_d[0]    = arb_id;
    for (int unsigned i = 1; i < PIPE_REGS; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_id_d[i]    = tag_id_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_valid_q <= '0;
      for (int unsigned i = 0; i < PIPE_REGS; i++) tag_id_q[i] <= '0;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
    end
  end

  always_comb begin
    core_rvalid_o = '0;
    if (tag_valid_q[PIPE_REGS-1]) core_rvalid_o[tag_id_q[PIPE_REGS-1]] = 1'b1;
  end

  assign core_result_o = unit_result_i;
  assign core_rflags_o = unit_flags_i;
  assign unit_busy_o   = |tag_valid_q;

endmodule

// File: doc/apu_shared_unit_arbiter.md
Name: apu_shared_unit_arbiter

Overview:
- Sits between NCORES core-side APU request ports and one shared, fixed-latency, fully pipelined FP unit (addsub, mult, mac, cast, div or sqrt).
- Round-robin arbitrates one request per cycle and drives the selected operands, op and flags into the unit.
- Tracks the issuing core ID through a tag pipeline matched to the unit latency, then routes the result and status flags back to that core.
- One instance per shared unit type when the matching PRIVATE_FP_* setting is 0.

Parameters:
- NCORES, 8, number of requesting cores (>=1).
- NARGS, 3, operands per request.
- WARG, FP_WIDTH (32), operand width.
- WRESULT, FP_WIDTH (32), result width.
- WOP, WOP_MAC (2), opcode width.
- NDSFLAGS, NDSFLAGS_MAC (3), downstream flags width (rounding mode).
- NUSFLAGS, NUSFLAGS_MAC (5), upstream status flags width.
- PIPE_REGS, C_MAC_PIPE_REGS (2), unit latency in cycles (>=1; 0 is an elaboration error).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- core_req_i  in  NCORES  per-core request
- core_operands_i  in  NCORES*NARGS*WARG  operands; core c occupies slice c
- core_op_i  in  NCORES*WOP  per-core opcode
- core_flags_i  in  NCORES*NDSFLAGS  per-core downstream flags
- core_gnt_o  out  NCORES  one-hot grant (combinational)
- core_rvalid_o  out  NCORES  one-hot result valid
- core_result_o  out  WRESULT  result, broadcast to all cores
- core_rflags_o  out  NUSFLAGS  status flags, broadcast to all cores
- unit_en_o  out  1  issue strobe to the shared unit
- unit_operands_o  out  NARGS*WARG  muxed operands
- unit_op_o  out  WOP  muxed opcode
- unit_flags_o  out  NDSFLAGS  muxed downstream flags
- unit_result_i  in  WRESULT  unit result, valid PIPE_REGS cycles after unit_en_o
- unit_flags_i  in  NUSFLAGS  unit status flags, aligned with unit_result_i
- unit_busy_o  out  1  at least one operation in flight

Behaviour:
- Reset values: rr_ptr=0; all tag valids=0; core_gnt_o=0; core_rvalid_o=0; unit_en_o=0; unit_busy_o=0.
- Grant, combinational:
  - Search core_req_i starting at rr_ptr, ascending, wrapping modulo NCORES.
  - The first requester k receives core_gnt_o[k]=1 in the same cycle.
  - At most one grant per cycle; no grant when core_req_i==0.
- Request protocol:
  - A core holds req, operands, op and flags stable until it sees gnt.
  - Deasserting req before gnt is legal; the request is simply withdrawn.
- Issue:
  - unit_en_o = |core_gnt_o.
  - unit_operands_o, unit_op_o and unit_flags_o take the granted core's slice.
  - When nothing is granted, these data outputs hold the slice at index rr_ptr (don't-care, but deterministic).
- Pointer update: on a grant to k, rr_ptr <= (k+1) mod NCORES at the clock edge. Otherwise rr_ptr holds.
- Tag pipeline:
  - PIPE_REGS stages of {valid, id}, with id width max(1, clog2(NCORES)).
  - Stage0 <= {unit_en_o, granted id}; stage i <= stage i-1 every cycle. The unit has no back-pressure and the pipeline never stalls.
- Return path:
  - When the last stage is valid with id=c, core_rvalid_o[c]=1 in that same cycle; all other bits are 0.
  - core_result_o = unit_result_i and core_rflags_o = unit_flags_i, combinational pass-through.
  - Latency: grant at cycle t produces rvalid at cycle t+PIPE_REGS.
  - Throughput is 1 per cycle. Back-to-back issues to the same or different cores return in order.
- unit_busy_o = OR of all tag-stage valids.
- Simultaneous events: issue and return in the same cycle are independent. A core may receive gnt and rvalid in the same cycle.
- NCORES=1: arbitration degenerates to gnt=req; rr_ptr stays 0.
- Reset mid-operation: all in-flight tags are discarded and no rvalid is produced for them. The attached unit must be reset on the same rst_i.

Decomposition:
- Add the shared-unit ID width function/constant and the PIPE_REGS>=1 limit to the shared apu cluster package. Reuse the existing C_*_PIPE_REGS, WOP_*, NDSFLAGS_* and NUSFLAGS_* constants there for defaults.
- One sub-module: apu_rr_arbiter (NCORES requests, rr pointer, one-hot grant plus encoded id). The tag pipeline and muxing stay in the top.

Test Plan:
- Single request: NCORES=8, PIPE_REGS=2, core 3 requests at cycle 0 with operands 0x3F800000 and 0x40000000. Expected: gnt[3] at cycle 0; unit_en_o=1 with core 3 operands; rvalid[3] at cycle 2 carrying unit_result_i; rr_ptr=4.
- All requesting: cores 0..7 hold req continuously. Expected: grants in order 0,1,...,7,0 on consecutive cycles; rvalid follows in the same order with a 2-cycle lag; unit_busy_o=1 throughout.
- Wrap-around fairness: rr_ptr=6, requests from cores 1 and 7. Expected: gnt[7] first, then gnt[1] on the next cycle, then rr_ptr=2.
- Withdrawn request: core 2 raises req, drops it before any grant while core 5 holds req. Expected: only gnt[5]; no unit_en_o and no rvalid attributed to core 2.
- Reset mid-flight: issue for core 4, assert rst_i one cycle later. Expected: all outputs 0 immediately (asynchronous); no rvalid[4] after release; rr_ptr=0.
- Edge parameters: PIPE_REGS=5 (sqrt) with NCORES=1 and continuous req. Expected: gnt every cycle; rvalid[0] from cycle 5 onward every cycle; unit_busy_o falls 5 cycles after req drops.
